sr_bank_arbiter: RTL

- Round-robin arbiter and sequencer for a shared WIDTH-bit bank of master-slave SR flip-flops.
- Grants one of NREQ requesters at a time and converts its (mask, op) command into per-bit s/r drive vectors.
- Holds s/r for one clock, then waits one settle clock for the slave stage before acknowledging.
- Guarantees the bank never sees s=1 and r=1 on the same bit.

---
 rtl/sr_bank_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter/sequencer driving a shared bank of master-slave SR flip-flops.
// Define SR_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module sr_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   mask,
  input  logic [WIDTH-1:0]        q_in,
  output logic [WIDTH-1:0]        s_out,
  output logic [WIDTH-1:0]        r_out,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StArb, StDrive, StSettle, StAck} state_e;

  state_e          state;
  logic [PW-1:0]   gnt_idx;
`ifndef SR_ARB_FIXED_PRIO_EN
  logic [PW-1:0]   ptr;
`endif

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [1:0]      pick_op;
  logic [WIDTH-1:0] pick_mask;
  logic [WIDTH-1:0] drv_s;
  logic [WIDTH-1:0] drv_r;

  // Scan in reverse search order so the last hit is the first requester in order.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
`ifdef SR_ARB_FIXED_PRIO_EN
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(i);
      end
    end
`else
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(idx);
      end
    end
`endif
    pick_op   = op[2*int'(pick_idx) +: 2];
    pick_mask = mask[WIDTH*int'(pick_idx) +: WIDTH];
  end

  // Toggle splits the mask by current state so s and r never overlap.
  always_comb begin
    drv_s = '0;
    drv_r = '0;
    case (pick_op)
      2'b01: drv_s = pick_mask;
      2'b10: drv_r = pick_mask;
      2'b11: begin
        drv_s = pick_mask & ~q_in;
        drv_r = pick_mask & q_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      gnt_idx <= '0;
`ifndef SR_ARB_FIXED_PRIO_EN
      ptr     <= '0;
`endif
      s_out   <= '0;
      r_out   <= '0;
      gnt     <= '0;
      ack     <= '0;
      busy    <= 1'b0;
    end else begin
      s_out <= '0;
      r_out <= '0;
      ack   <= '0;
      case (state)
        StIdle: begin
          if (|req) begin
            state <= StArb;
            busy  <= 1'b1;
          end
        end
        StArb: begin
          if (pick_vld) begin
            state   <= StDrive;
            gnt     <= NREQ'(1) << pick_idx;
            gnt_idx <= pick_idx;
            s_out   <= drv_s;
            r_out   <= drv_r;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        StDrive:  state <= StSettle;
        StSettle: begin
          state <= StAck;
          ack   <= gnt;
        end
        StAck: begin
          state <= StIdle;
          gnt   <= '0;
          busy  <= 1'b0;
`ifndef SR_ARB_FIXED_PRIO_EN
          ptr   <= (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
`endif
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
